// File: rtl/emu_seq_ctrl_pkg.sv
// Shared types and constants for the emulator step controller.
// State codes stay plain 3-bit constants so legacy tooling can decode them.
package emu_seq_pkg;

   typedef logic [2:0] state_t;

   localparam state_t IDLE     = 3'd0;
   localparam state_t INIT     = 3'd1;
   localparam state_t RELEASE  = 3'd2;
   localparam state_t WAIT_EXP = 3'd3;
   localparam state_t CHECK    = 3'd4;
   localparam state_t PULSE    = 3'd5;
   localparam state_t FIN      = 3'd6;

   // Guard bits added above WIDTH so exp +/- tol never wraps at full-scale codes.
   localparam int CMP_GUARD = 2;

   function automatic int cmp_width(input int width);
      return width + CMP_GUARD;
   endfunction

endpackage

// File: rtl/emu_seq_ctrl_if.sv
// Expected-value stream from the host/ROM into the step controller.
interface emu_seq_ctrl_if #(
   parameter int N_CH  = 1,
   parameter int WIDTH = 25
);
   logic                  exp_valid;
   logic                  exp_ready;
   logic [N_CH*WIDTH-1:0] exp_data;

   modport master (output exp_valid, output exp_data, input exp_ready);
   modport slave  (input exp_valid, input exp_data, output exp_ready);
endinterface

// File: rtl/emu_seq_ctrl_tol.sv
// Single-channel band check: ok = (expt - tol <= meas <= expt + tol), all signed.
module emu_tol_check
   import emu_seq_pkg::*;
#(
   parameter int WIDTH = 25
) (
   input  logic signed [WIDTH-1:0] meas,
   input  logic signed [WIDTH-1:0] expt,
   input  logic signed [WIDTH-1:0] tol,
   output logic                    ok
);
   localparam int XW = cmp_width(WIDTH);

   logic signed [XW-1:0] meas_x, lo_x, hi_x;

   always_comb begin
      meas_x = {{CMP_GUARD{meas[WIDTH-1]}}, meas};
      lo_x   = {{CMP_GUARD{expt[WIDTH-1]}}, expt} - {{CMP_GUARD{tol[WIDTH-1]}}, tol};
      hi_x   = {{CMP_GUARD{expt[WIDTH-1]}}, expt} + {{CMP_GUARD{tol[WIDTH-1]}}, tol};
      ok     = (lo_x <= meas_x) && (meas_x <= hi_x);
   end
endmodule

// File: rtl/emu_seq_ctrl.sv
// Emulator step controller: DUT reset sequencing, stimulus hold, and
// check-then-step loop against a streamed expected-value channel.
module emu_seq_ctrl
   import emu_seq_pkg::*;
#(
   parameter int N_CH    = 1,
   parameter int WIDTH   = 25,
   parameter int STEP_W  = 16,
   parameter int RST_CYC = 8,
   parameter int GO_HI   = 1,
   parameter int GO_LO   = 1,
   parameter int SETTLE  = 2
) (
   input  logic                  emu_clk,
   input  logic                  emu_rst_n,
   input  logic                  start,
   input  logic [STEP_W-1:0]     n_steps,
   input  logic [WIDTH-1:0]      abs_tol,
   input  logic [N_CH*WIDTH-1:0] v_in_cfg,
   input  logic [N_CH*WIDTH-1:0] v_out,
   emu_seq_ctrl_if.slave         exp_if,
   output logic                  go,
   output logic                  dut_rst,
   output logic [N_CH*WIDTH-1:0] v_in,
   output logic                  busy,
   output logic                  done,
   output logic                  pass,
   output logic [STEP_W-1:0]     err_cnt,
   output logic [N_CH-1:0]       fail_mask,
   output logic [STEP_W-1:0]     step_idx
);
   localparam int PULSE_CYC = GO_HI + GO_LO;
   localparam int CNT_MAX   = (RST_CYC > SETTLE)
                              ? ((RST_CYC > PULSE_CYC) ? RST_CYC : PULSE_CYC)
                              : ((SETTLE > PULSE_CYC) ? SETTLE : PULSE_CYC);
   localparam int CNT_W     = $clog2(CNT_MAX + 1);

   localparam logic [CNT_W-1:0] INIT_LAST   = CNT_W'(RST_CYC - 1);
   localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE - 1);
   localparam logic [CNT_W-1:0] PULSE_LAST  = CNT_W'(PULSE_CYC - 1);
   localparam logic [CNT_W-1:0] GO_HI_C     = CNT_W'(GO_HI);

   state_t                state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic                  go_q, go_d;
   logic                  dut_rst_q, dut_rst_d;
   logic                  exp_ready_q, exp_ready_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;
   logic                  pass_q, pass_d;
   logic [STEP_W-1:0]     err_cnt_q, err_cnt_d;
   logic [N_CH-1:0]       fail_mask_q, fail_mask_d;
   logic [STEP_W-1:0]     step_idx_q, step_idx_d;
   logic [STEP_W-1:0]     n_steps_q, n_steps_d;
   logic [WIDTH-1:0]      tol_q, tol_d;
   logic [N_CH*WIDTH-1:0] v_in_q, v_in_d;
   logic [N_CH*WIDTH-1:0] exp_q, exp_d;
   logic [N_CH-1:0]       ok;

   for (genvar c = 0; c < N_CH; c++) begin : g_chk
      emu_tol_check #(.WIDTH(WIDTH)) u_chk (
         .meas (v_out[c*WIDTH +: WIDTH]),
         .expt (exp_q[c*WIDTH +: WIDTH]),
         .tol  (tol_q),
         .ok   (ok[c])
      );
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      go_d        = 1'b0;
      dut_rst_d   = dut_rst_q;
      exp_ready_d = exp_ready_q;
      busy_d      = busy_q;
      done_d      = done_q;
      pass_d      = pass_q;
      err_cnt_d   = err_cnt_q;
      fail_mask_d = fail_mask_q;
      step_idx_d  = step_idx_q;
      n_steps_d   = n_steps_q;
      tol_d       = tol_q;
      v_in_d      = v_in_q;
      exp_d       = exp_q;
      case (state_q)
         IDLE: if (start) begin
            n_steps_d   = n_steps;
            tol_d       = abs_tol;
            v_in_d      = v_in_cfg;
            done_d      = 1'b0;
            pass_d      = 1'b0;
            err_cnt_d   = '0;
            fail_mask_d = '0;
            step_idx_d  = '0;
            busy_d      = 1'b1;
            dut_rst_d   = 1'b1;
            cnt_d       = '0;
            state_d     = INIT;
         end
         INIT: begin
            // go lands in INIT cycle 1 so the DUT samples its reset once.
            go_d = (cnt_q == '0);
            if (cnt_q == INIT_LAST) begin
               cnt_d     = '0;
               dut_rst_d = 1'b0;
               state_d   = RELEASE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         RELEASE: begin
            if (cnt_q == SETTLE_LAST) begin
               cnt_d = '0;
               if (n_steps_q == '0) begin
                  state_d = FIN;
               end else begin
                  exp_ready_d = 1'b1;
                  state_d     = WAIT_EXP;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         WAIT_EXP: if (exp_if.exp_valid && exp_ready_q) begin
            exp_d       = exp_if.exp_data;
            exp_ready_d = 1'b0;
            state_d     = CHECK;
         end
         CHECK: begin
            if (!(&ok) && !(&err_cnt_q)) err_cnt_d = err_cnt_q + 1'b1;
            fail_mask_d = fail_mask_q | ~ok;
            cnt_d       = '0;
            go_d        = 1'b1;
            state_d     = PULSE;
         end
         PULSE: begin
            if (cnt_q == PULSE_LAST) begin
               cnt_d      = '0;
               step_idx_d = step_idx_q + 1'b1;
               if (step_idx_d == n_steps_q) begin
                  state_d = FIN;
               end else begin
                  exp_ready_d = 1'b1;
                  state_d     = WAIT_EXP;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
               go_d  = ((cnt_q + 1'b1) < GO_HI_C);
            end
         end
         FIN: begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = (err_cnt_q == '0);
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge emu_clk or negedge emu_rst_n) begin
      if (!emu_rst_n) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         go_q        <= 1'b0;
         dut_rst_q   <= 1'b1;
         exp_ready_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         pass_q      <= 1'b0;
         err_cnt_q   <= '0;
         fail_mask_q <= '0;
         step_idx_q  <= '0;
         n_steps_q   <= '0;
         tol_q       <= '0;
         v_in_q      <= '0;
         exp_q       <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         go_q        <= go_d;
         dut_rst_q   <= dut_rst_d;
         exp_ready_q <= exp_ready_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         pass_q      <= pass_d;
         err_cnt_q   <= err_cnt_d;
         fail_mask_q <= fail_mask_d;
         step_idx_q  <= step_idx_d;
         n_steps_q   <= n_steps_d;
         tol_q       <= tol_d;
         v_in_q      <= v_in_d;
         exp_q       <= exp_d;
      end
   end

   assign go               = go_q;
   assign dut_rst          = dut_rst_q;
   assign v_in             = v_in_q;
   assign busy             = busy_q;
   assign done             = done_q;
   assign pass             = pass_q;
   assign err_cnt          = err_cnt_q;
   assign fail_mask        = fail_mask_q;
   assign step_idx         = step_idx_q;
   assign exp_if.exp_ready = exp_ready_q;
endmodule

// File: tb/tb_emu_seq_ctrl.sv
// Bench for emu_seq_ctrl: a toy emulated DUT whose outputs come from a table
// indexed by go pulses since reset release, plus a timestamp model of the controller.
module tb_emu_seq_ctrl;
   localparam int N_CH = 2, WIDTH = 25, STEP_W = 16;
   localparam int RST_CYC = 8, GO_HI = 1, GO_LO = 1, SETTLE = 2;
   localparam longint MAXV = (64'sd1 <<< (WIDTH - 1)) - 1;
   localparam longint MINV = -(64'sd1 <<< (WIDTH - 1));

   logic emu_clk = 1'b0, emu_rst_n;
   logic start;
   logic [STEP_W-1:0] n_steps;
   logic [WIDTH-1:0] abs_tol;
   logic [N_CH*WIDTH-1:0] v_in_cfg, v_out, v_in, exp_w;
   logic go, dut_rst, busy, done, pass;
   logic [STEP_W-1:0] err_cnt, step_idx;
   logic [N_CH-1:0] fail_mask;

   emu_seq_ctrl_if #(.N_CH(N_CH), .WIDTH(WIDTH)) exp_if ();

   emu_seq_ctrl #(.N_CH(N_CH), .WIDTH(WIDTH), .STEP_W(STEP_W), .RST_CYC(RST_CYC),
                  .GO_HI(GO_HI), .GO_LO(GO_LO), .SETTLE(SETTLE)) dut (
      .emu_clk(emu_clk), .emu_rst_n(emu_rst_n), .start(start), .n_steps(n_steps),
      .abs_tol(abs_tol), .v_in_cfg(v_in_cfg), .v_out(v_out), .exp_if(exp_if),
      .go(go), .dut_rst(dut_rst), .v_in(v_in), .busy(busy), .done(done), .pass(pass),
      .err_cnt(err_cnt), .fail_mask(fail_mask), .step_idx(step_idx));

   always #5 emu_clk = ~emu_clk;

   // Emulated DUT and expected-value source
   longint vtab [8][N_CH];
   longint etab [8][N_CH];
   int dcnt = 0, eidx = 0, go_seen = 0;

   always @(posedge emu_clk) begin
      if (go) dcnt <= dut_rst ? 0 : dcnt + 1;
      if (start && !busy) eidx <= 0;
      else if (exp_if.exp_valid && exp_if.exp_ready) eidx <= eidx + 1;
      if (start && !busy) go_seen <= 0;
      else if (go) go_seen <= go_seen + 1;
   end

   always_comb begin
      v_out = '0;
      exp_w = '0;
      for (int c = 0; c < N_CH; c++) begin
         v_out[c*WIDTH +: WIDTH] = WIDTH'(vtab[(dcnt > 7) ? 7 : dcnt][c]);
         exp_w[c*WIDTH +: WIDTH] = WIDTH'(etab[(eidx > 7) ? 7 : eidx][c]);
      end
   end
   assign exp_if.exp_data = exp_w;

   int n_pass = 0, n_tot = 0;
   longint t = 0;

   task automatic chk(input string nm, input longint act, input longint req);
      n_tot++;
      if (act == req) n_pass++;
      else $display("FAIL %s: got %0d want %0d (cycle %0d)", nm, act, req, t);
   endtask

   // Timestamp model: each phase boundary is a cycle number derived from the
   // start edge and handshake edges; outputs follow from those stamps.
   bit busy_m, done_m, pass_m, started;
   int n_m, err_m, step_m;
   logic [N_CH-1:0] mask_m;
   logic [N_CH*WIDTH-1:0] vin_m;
   longint tol_m, exp_m [N_CH];
   longint t_start, t_rel, t_ready, t_chk, t_fin;

   task automatic m_reset();
      busy_m = 0; done_m = 0; pass_m = 0; started = 0;
      err_m = 0; step_m = 0; mask_m = '0; vin_m = '0;
      t_start = -10; t_rel = 0; t_ready = -1; t_chk = -1; t_fin = -1;
   endtask

   always @(negedge emu_clk) begin
      bit ge, any_bad;
      longint e, v;
      t++;
      if (!emu_rst_n) begin
         m_reset();
         chk("rst_go", go, 0);
         chk("rst_dut_rst", dut_rst, 1);
         chk("rst_busy", busy, 0);
         chk("rst_done", done, 0);
      end else begin
         ge = (started && t == t_start + 1) || (t_chk >= 0 && t > t_chk && t <= t_chk + GO_HI);
         chk("m_go", go, ge);
         chk("m_dut_rst", dut_rst, !(started && t >= t_rel));
         chk("m_exp_ready", exp_if.exp_ready, (t_ready >= 0 && t >= t_ready));
         chk("m_busy", busy, busy_m);
         chk("m_done", done, done_m);
         if (done_m) chk("m_pass", pass, pass_m);
         chk("m_err_cnt", err_cnt, err_m);
         chk("m_fail_mask", fail_mask, mask_m);
         chk("m_step_idx", step_idx, step_m);
         chk("m_v_in", v_in, vin_m);
         // advance model to the values expected after the next edge
         if (!busy_m && start) begin
            started = 1; t_start = t + 1; t_rel = t + 1 + RST_CYC;
            n_m = n_steps; tol_m = abs_tol; vin_m = v_in_cfg;
            busy_m = 1; done_m = 0; pass_m = 0; err_m = 0; mask_m = '0; step_m = 0;
            t_chk = -1; t_ready = -1; t_fin = -1;
            if (n_m == 0) t_fin = t + 1 + RST_CYC + SETTLE;
            else t_ready = t + 1 + RST_CYC + SETTLE;
         end else begin
            if (t_ready >= 0 && t >= t_ready && exp_if.exp_valid) begin
               t_chk = t + 1; t_ready = -1;
               for (int c = 0; c < N_CH; c++) exp_m[c] = longint'($signed(exp_if.exp_data[c*WIDTH +: WIDTH]));
            end
            if (t == t_chk) begin
               any_bad = 0;
               for (int c = 0; c < N_CH; c++) begin
                  v = longint'($signed(v_out[c*WIDTH +: WIDTH]));
                  e = exp_m[c];
                  if (v < e - tol_m || v > e + tol_m) begin any_bad = 1; mask_m[c] = 1'b1; end
               end
               if (any_bad && err_m < (1 << STEP_W) - 1) err_m++;
            end
            if (t_chk >= 0 && t == t_chk + GO_HI + GO_LO) begin
               step_m++;
               if (step_m == n_m) t_fin = t + 1; else t_ready = t + 1;
            end
            if (t == t_fin) begin
               busy_m = 0; done_m = 1; pass_m = (err_m == 0); t_fin = -1;
            end
         end
      end
   end

   task automatic set_same(input longint b0, input longint d0, input longint b1, input longint d1);
      for (int k = 0; k < 8; k++) begin
         etab[k][0] = b0 + d0 * k; vtab[k][0] = b0 + d0 * k;
         etab[k][1] = b1 + d1 * k; vtab[k][1] = b1 + d1 * k;
      end
   endtask

   task automatic do_start(input int n, input longint tol, input longint cfg0, input longint cfg1);
      @(posedge emu_clk); #1;
      n_steps = STEP_W'(n); abs_tol = WIDTH'(tol);
      v_in_cfg = {WIDTH'(cfg1), WIDTH'(cfg0)};
      start = 1'b1;
      @(posedge emu_clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_done(input string nm, input int budget);
      int i = 0;
      while (done !== 1'b1 && i < budget) begin @(posedge emu_clk); #1; i++; end
      chk({nm, "_done_in_time"}, done, 1);
   endtask

   task automatic post(input string nm, input int err, input int mask, input int ps,
                       input int gos, input int steps);
      chk({nm, "_err_cnt"}, err_cnt, err);
      chk({nm, "_fail_mask"}, fail_mask, mask);
      chk({nm, "_pass"}, pass, ps);
      chk({nm, "_go_pulses"}, go_seen, gos);
      chk({nm, "_step_idx"}, step_idx, steps);
      chk({nm, "_busy"}, busy, 0);
      chk({nm, "_v_in"}, v_in, v_in_cfg);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int i;
      start = 0; n_steps = '0; abs_tol = '0; v_in_cfg = '0;
      exp_if.exp_valid = 1'b0; emu_rst_n = 1'b0;
      set_same(0, 0, 0, 0);
      repeat (3) @(posedge emu_clk);
      #1;
      chk("reset_go", go, 0);
      chk("reset_dut_rst", dut_rst, 1);
      chk("reset_exp_ready", exp_if.exp_ready, 0);
      chk("reset_err_cnt", err_cnt, 0);
      chk("reset_step_idx", step_idx, 0);
      chk("reset_v_in", v_in, 0);
      emu_rst_n = 1'b1;
      exp_if.exp_valid = 1'b1;

      // A: basic 3-step run, always matching
      set_same(3, 10, 0, -20);
      do_start(3, 4, 11, -7);
      wait_done("A", 300);
      post("A", 0, 0, 1, 4, 3);

      // B: band edges on channel 0
      set_same(0, 0, 0, 0);
      etab[0][0] = 100;  vtab[0][0] = 104;
      etab[1][0] = 100;  vtab[1][0] = 96;
      etab[2][0] = 100;  vtab[2][0] = 105;
      etab[3][0] = MAXV; vtab[3][0] = MINV;
      etab[4][0] = MAXV; vtab[4][0] = MAXV;
      etab[5][0] = MINV; vtab[5][0] = MINV;
      do_start(6, 4, -1, 5);
      wait_done("B", 400);
      post("B", 2, 1, 0, 7, 6);

      // C: channel 1 off by 5 on steps 1 and 3
      set_same(1, 10, 2, 7);
      vtab[1][1] = vtab[1][1] + 5;
      vtab[3][1] = vtab[3][1] + 5;
      do_start(4, 4, 3, 9);
      wait_done("C", 400);
      post("C", 2, 2, 0, 5, 4);

      // D: stall before step 2, with an ignored start mid-run
      set_same(-50, 3, 8, -1);
      do_start(3, 0, 21, 22);
      i = 0;
      while (eidx != 2 && i < 200) begin @(posedge emu_clk); #1; i++; end
      chk("D_reach_step2", eidx, 2);
      exp_if.exp_valid = 1'b0;
      repeat (10) @(posedge emu_clk);
      #1;
      n_steps = 16'd7; start = 1'b1;
      @(posedge emu_clk); #1;
      start = 1'b0; n_steps = 16'd3;
      repeat (40) @(posedge emu_clk);
      #1;
      chk("D_stall_go", go, 0);
      chk("D_stall_exp_ready", exp_if.exp_ready, 1);
      chk("D_stall_busy", busy, 1);
      chk("D_stall_step_idx", step_idx, 2);
      chk("D_stall_go_pulses", go_seen, 3);
      exp_if.exp_valid = 1'b1;
      wait_done("D", 300);
      post("D", 0, 0, 1, 4, 3);

      // E: zero steps
      do_start(0, 4, 0, 1);
      wait_done("E", 100);
      post("E", 0, 0, 1, 1, 0);

      // F: reset during a step pulse, then a clean rerun
      set_same(3, 10, 0, -20);
      do_start(3, 4, 5, 6);
      i = 0;
      while (!(go === 1'b1 && dut_rst === 1'b0) && i < 200) begin @(posedge emu_clk); #1; i++; end
      chk("F_reach_pulse", go, 1);
      #2 emu_rst_n = 1'b0;
      #1;
      chk("F_abort_go", go, 0);
      chk("F_abort_dut_rst", dut_rst, 1);
      chk("F_abort_done", done, 0);
      chk("F_abort_busy", busy, 0);
      chk("F_abort_step_idx", step_idx, 0);
      @(posedge emu_clk); #1;
      emu_rst_n = 1'b1;
      do_start(3, 4, 12, 13);
      wait_done("F", 300);
      post("F", 0, 0, 1, 4, 3);

      repeat (3) @(posedge emu_clk);
      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end
endmodule

// File: doc/emu_seq_ctrl.md
Name: emu_seq_ctrl

Overview:
Synthesizable on-fabric successor to the testbench-side emulator step controller. It sequences the DUT reset, holds per-channel stimulus, and issues a programmable number of single-step "go" pulses. Before each step it checks every output channel against a streamed expected value within an absolute tolerance band. It sits between the emulator core (go / dut_rst / v_in / v_out) and a host or ROM that supplies expected values, so regression runs need no VIO round-trips.

Parameters:
N_CH, 1, number of analog channels (in and out)
WIDTH, 25, signed fixed-point word width per channel
STEP_W, 16, width of step counter and n_steps
RST_CYC, 8, emu_clk cycles dut_rst held high during INIT (>=3)
GO_HI, 1, cycles go is high per step (>=1)
GO_LO, 1, cycles go is low after each pulse (>=1)
SETTLE, 2, cycles between dut_rst release and first check (>=1)

Ports:
emu_clk  in  1  emulator clock
emu_rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle run request, honoured only in IDLE
n_steps  in  STEP_W  number of steps, sampled on accepted start
abs_tol  in  WIDTH  non-negative tolerance, sampled on accepted start
v_in_cfg  in  N_CH*WIDTH  stimulus words, sampled on accepted start
v_out  in  N_CH*WIDTH  DUT outputs, signed
exp_valid  in  1  expected-value word available
exp_ready  out  1  controller accepts expected word
exp_data  in  N_CH*WIDTH  expected outputs for current step, signed
go  out  1  emulator step enable
dut_rst  out  1  DUT reset, active high
v_in  out  N_CH*WIDTH  registered stimulus
busy  out  1  run in progress
done  out  1  sticky run-complete flag, cleared by next accepted start
pass  out  1  valid when done: 1 iff err_cnt==0
err_cnt  out  STEP_W  saturating count of failed checks (per step, not per channel)
fail_mask  out  N_CH  sticky per-channel failure bits
step_idx  out  STEP_W  index of current step

Behaviour:
- Reset values: go=0, dut_rst=1, v_in=0, exp_ready=0, busy=0, done=0, pass=0, err_cnt=0, fail_mask=0, step_idx=0. FSM goes to IDLE. Asserting reset mid-run aborts the run immediately, with no completion flag.
- All outputs are registered. The FSM has seven states:
- IDLE: on start, latch n_steps, abs_tol and v_in_cfg; v_in<=v_in_cfg; clear done, err_cnt, fail_mask, step_idx; busy<=1; go to INIT.
- INIT: dut_rst=1 for RST_CYC cycles. go is high in exactly cycle 1 of INIT (0-based) to clock reset into the DUT. Then go to RELEASE.
- RELEASE: dut_rst<=0; wait SETTLE cycles. If the latched n_steps==0, go to FIN; else go to WAIT_EXP.
- WAIT_EXP: exp_ready=1. On exp_valid&&exp_ready, latch exp_data, drop exp_ready next cycle, go to CHECK. exp_ready is never high outside WAIT_EXP. There is no timeout; the controller stalls indefinitely.
- CHECK: one cycle. For every channel c, ok[c] = (exp-tol <= v_out) && (v_out <= exp+tol). Arithmetic is signed, sign-extended to WIDTH+2 bits, so no overflow at full-scale codes.
  - On any !ok: err_cnt+=1, saturating at all-ones.
  - fail_mask |= ~ok.
  - Then go to PULSE.
- PULSE: go=1 for GO_HI cycles, then go=0 for GO_LO cycles. step_idx increments on the last GO_LO cycle. If the new step_idx==n_steps, go to FIN; else go to WAIT_EXP.
- FIN: busy<=0, done<=1, pass<=(err_cnt==0); go to IDLE. dut_rst stays 0 and v_in holds until the next start.
- start while busy is ignored. start and exp_valid in the same cycle are independent.
- Check-before-step ordering: the check for step k uses v_out after k go pulses since reset release. Step 0 therefore checks the post-reset state.

Decomposition:
- Package emu_seq_pkg: state_t enum {IDLE, INIT, RELEASE, WAIT_EXP, CHECK, PULSE, FIN}, and the localparam for extended compare width (WIDTH+2).
- Sub-module emu_tol_check: combinational single-channel band comparator (WIDTH parameter; inputs meas, expt, tol; output ok). Instantiated N_CH times via generate.

Test Plan:
- Basic run, N_CH=1, n_steps=3, abs_tol=4, exp_data always equals v_out: exactly 3 go pulses after INIT (plus the single INIT go), done=1, pass=1, err_cnt=0.
- Band edges, abs_tol=4: exp=100 with v_out=104 and v_out=96 -> pass; v_out=105 -> err_cnt=1, fail_mask[0]=1. Also exp=2^24-1 with v_out=-2^24 -> fail, with no wrap-induced pass.
- N_CH=2, n_steps=4, channel 1 mismatched on steps 1 and 3 -> err_cnt=2, fail_mask=2'b10, pass=0.
- Stall: withhold exp_valid for 50 cycles at step 2 -> go stays 0, exp_ready stays 1, busy=1; the run resumes on valid with the step count unchanged.
- n_steps=0 -> only the INIT go pulse occurs, done=1, pass=1. A start asserted while busy in another run leaves the latched n_steps unchanged.
- Assert emu_rst_n low during PULSE -> go=0 and dut_rst=1 asynchronously, done=0. After release, a new start runs cleanly from step_idx=0.
